adc_scan_sequencer: RTL and testbench

Sequences the MAX10 on-chip ADC hard block across a programmable set of analog channels. It drives channel select and start-of-conversion, waits for end-of-conversion, and captures each 12-bit unsigned result. Each result is converted to a signed, sign-extended sample and presented downstream with a valid/ready handshake. It sits between the ADC wrapper and the effect datapath, replacing a fixed single-channel, free-running connection.

---
 rtl/adc_seq_pkg.sv | 23 ++
 rtl/rr_pick8.sv | 27 ++
 rtl/adc_scan_sequencer.sv | 174 +++++++++++++++++
 tb/tb_adc_scan_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_seq_pkg.sv
// Shared types, constants and the ADC-code conversion for the ADC scan sequencer.
package adc_seq_pkg;

    localparam int unsigned CH_COUNT     = 8;
    localparam int unsigned CH_IDX_W     = $clog2(CH_COUNT);
    localparam int unsigned CHSEL_W      = 5;
    localparam int unsigned CHSEL_OFFSET = 1;
    localparam int unsigned ADC_BITS     = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PICK,
        ST_SETTLE,
        ST_CONVERT,
        ST_CAPTURE
    } state_e;

    // Offset-binary ADC code to two's complement: flip the MSB.
    function automatic logic signed [ADC_BITS-1:0] u12_to_signed(input logic [ADC_BITS-1:0] u);
        return signed'({~u[ADC_BITS-1], u[ADC_BITS-2:0]});
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin finder: next set mask bit after last_idx, wrapping.
module rr_pick8
    import adc_seq_pkg::*;
(
    input  logic [CH_COUNT-1:0] mask,
    input  logic [CH_IDX_W-1:0] last_idx,
    output logic [CH_IDX_W-1:0] next_idx_c,
    output logic                found_c
);

    logic [CH_IDX_W-1:0] cand;

    // Walk from the farthest offset down so the nearest set bit wins; offset 8 is last_idx itself.
    always_comb begin
        next_idx_c = '0;
        found_c    = 1'b0;
        cand       = '0;
        for (int i = CH_COUNT; i >= 1; i--) begin
            cand = last_idx + CH_IDX_W'(i);
            if (mask[cand]) begin
                next_idx_c = cand;
                found_c    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Round-robin multi-channel sequencer for the MAX10 ADC hard block with a
// one-entry valid/ready output register and sticky overrun/timeout flags.
module adc_scan_sequencer
    import adc_seq_pkg::*;
#(
    parameter int unsigned BIT_DEPTH      = 12,
    parameter int unsigned TARGET_DEPTH   = 16,
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_enable,
    input  logic [CH_COUNT-1:0]     i_ch_mask,
    output logic [CHSEL_W-1:0]      o_adc_chsel,
    output logic                    o_adc_soc,
    input  logic                    i_adc_eoc,
    input  logic [BIT_DEPTH-1:0]    i_adc_dout,
    output logic [TARGET_DEPTH-1:0] o_sample,
    output logic [CH_IDX_W-1:0]     o_sample_ch,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic                    o_overrun,
    output logic                    o_timeout,
    input  logic                    i_clear
);

    localparam int unsigned SETTLE_W = 8;
    localparam int unsigned TMO_W    = $clog2(TIMEOUT_CYCLES + 1);

    state_e                  state_q, state_d;
    logic [CH_IDX_W-1:0]     last_idx_q, last_idx_d;
    logic [CHSEL_W-1:0]      chsel_q, chsel_d;
    logic                    soc_q, soc_d;
    logic [SETTLE_W-1:0]     settle_q, settle_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic                    eoc_q;
    logic [BIT_DEPTH-1:0]    hold_q, hold_d;
    logic [TARGET_DEPTH-1:0] sample_q, sample_d;
    logic [CH_IDX_W-1:0]     sample_ch_q, sample_ch_d;
    logic                    valid_q, valid_d;
    logic                    overrun_q, overrun_d;
    logic                    timeout_q, timeout_d;

    logic                    eoc_rise;
    logic [CH_IDX_W-1:0]     pick_idx;
    logic                    pick_found;
    logic signed [ADC_BITS-1:0] conv;

    rr_pick8 u_pick (
        .mask       (i_ch_mask),
        .last_idx   (last_idx_q),
        .next_idx_c (pick_idx),
        .found_c    (pick_found)
    );

    assign eoc_rise = i_adc_eoc & ~eoc_q;
    assign conv     = u12_to_signed(ADC_BITS'(hold_q));

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            last_idx_q  <= CH_IDX_W'(CH_COUNT - 1);
            chsel_q     <= CHSEL_W'(CHSEL_OFFSET);
            soc_q       <= 1'b0;
            settle_q    <= '0;
            tmo_q       <= '0;
            eoc_q       <= 1'b0;
            hold_q      <= '0;
            sample_q    <= '0;
            sample_ch_q <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_idx_q  <= last_idx_d;
            chsel_q     <= chsel_d;
            soc_q       <= soc_d;
            settle_q    <= settle_d;
            tmo_q       <= tmo_d;
            eoc_q       <= i_adc_eoc;
            hold_q      <= hold_d;
            sample_q    <= sample_d;
            sample_ch_q <= sample_ch_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            timeout_q   <= timeout_d;
        end
    end

    // Next state, soc (asserted for the cycles spent in CONVERT) and output register.
    always_comb begin
        state_d     = state_q;
        last_idx_d  = last_idx_q;
        chsel_d     = chsel_q;
        soc_d       = 1'b0;
        settle_d    = settle_q;
        tmo_d       = tmo_q;
        hold_d      = hold_q;
        sample_d    = sample_q;
        sample_ch_d = sample_ch_q;
        valid_d     = valid_q & ~i_ready;
        overrun_d   = overrun_q;
        timeout_d   = timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (i_enable && (|i_ch_mask)) begin
                    state_d = ST_PICK;
                end
            end
            ST_PICK: begin
                if (pick_found && i_enable) begin
                    last_idx_d = pick_idx;
                    chsel_d    = CHSEL_W'(pick_idx) + CHSEL_W'(CHSEL_OFFSET);
                    settle_d   = '0;
                    state_d    = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (settle_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                    tmo_d   = '0;
                    soc_d   = 1'b1;
                    state_d = ST_CONVERT;
                end else begin
                    settle_d = settle_q + SETTLE_W'(1);
                end
            end
            ST_CONVERT: begin
                if (eoc_rise) begin
                    hold_d  = i_adc_dout;
                    state_d = ST_CAPTURE;
                end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_PICK;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                    soc_d = 1'b1;
                end
            end
            ST_CAPTURE: begin
                sample_d    = TARGET_DEPTH'(conv);
                sample_ch_d = last_idx_q;
                valid_d     = 1'b1;
                if (valid_q && !i_ready) begin
                    overrun_d = 1'b1;
                end
                state_d = i_enable ? ST_PICK : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Clear beats a same-cycle set.
        if (i_clear) begin
            overrun_d = 1'b0;
            timeout_d = 1'b0;
        end
    end

    assign o_adc_chsel = chsel_q;
    assign o_adc_soc   = soc_q;
    assign o_sample    = sample_q;
    assign o_sample_ch = sample_ch_q;
    assign o_valid     = valid_q;
    assign o_overrun   = overrun_q;
    assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed + randomized bench for adc_scan_sequencer with a behavioural ADC and
// a round-robin / offset-binary reference model.
module tb_adc_scan_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_enable;
    logic [7:0]  i_ch_mask;
    logic [4:0]  o_adc_chsel;
    logic        o_adc_soc;
    logic        i_adc_eoc;
    logic [11:0] i_adc_dout;
    logic [15:0] o_sample;
    logic [2:0]  o_sample_ch;
    logic        o_valid;
    logic        i_ready;
    logic        o_overrun;
    logic        o_timeout;
    logic        i_clear;

    int total = 0;
    int bad   = 0;

    // ADC model controls: 0 dout=chsel*0x100, 1 fixed, 2 never eoc, 3 random
    int          adc_mode  = 0;
    int          eoc_delay = 20;
    logic [11:0] fixed_dout = '0;
    int          adc_cnt = 0;
    logic        soc_prev = 1'b0;

    logic [4:0]  soc_log[$];
    logic [11:0] dout_log[$];
    logic [15:0] rcv_val[$];
    logic [2:0]  rcv_ch[$];

    adc_scan_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_enable    (i_enable),
        .i_ch_mask   (i_ch_mask),
        .o_adc_chsel (o_adc_chsel),
        .o_adc_soc   (o_adc_soc),
        .i_adc_eoc   (i_adc_eoc),
        .i_adc_dout  (i_adc_dout),
        .o_sample    (o_sample),
        .o_sample_ch (o_sample_ch),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_overrun   (o_overrun),
        .o_timeout   (o_timeout),
        .i_clear     (i_clear)
    );

    always #5 clk = ~clk;

    // Behavioural ADC: eoc pulse eoc_delay cycles after soc rises, garbage dout otherwise.
    always @(negedge clk) begin
        i_adc_eoc  = 1'b0;
        i_adc_dout = 12'($urandom);
        if (!rst_n) begin
            adc_cnt  = 0;
            soc_prev = 1'b0;
        end else begin
            if (o_adc_soc && !soc_prev) begin
                soc_log.push_back(o_adc_chsel);
                if (adc_mode != 2) adc_cnt = eoc_delay;
            end
            if (!o_adc_soc) begin
                adc_cnt = 0;
            end else if (adc_cnt > 0) begin
                adc_cnt--;
                if (adc_cnt == 0) begin
                    i_adc_eoc = 1'b1;
                    case (adc_mode)
                        0:       i_adc_dout = {o_adc_chsel[3:0], 8'h00};
                        1:       i_adc_dout = fixed_dout;
                        default: i_adc_dout = 12'($urandom);
                    endcase
                    dout_log.push_back(i_adc_dout);
                end
            end
            soc_prev = o_adc_soc;
        end
    end

    // Completed handshakes.
    always @(posedge clk) begin
        if (rst_n && o_valid && i_ready) begin
            rcv_val.push_back(o_sample);
            rcv_ch.push_back(o_sample_ch);
        end
    end

    function automatic logic [15:0] exp_sample(input logic [11:0] code);
        return 16'(int'(code) - 2048);
    endfunction

    function automatic int next_ch(input logic [7:0] mask, input int last);
        for (int off = 1; off <= 8; off++) begin
            if (mask[(last + off) % 8]) return (last + off) % 8;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        soc_log.delete();
        dout_log.delete();
        rcv_val.delete();
        rcv_ch.delete();
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int          n;
        int          cnt;
        int          ch;
        int          m_last;
        logic        ok;
        logic [7:0]  rmask;
        logic [11:0] codes[3];
        logic [15:0] held;

        rst_n = 1'b0; i_enable = 1'b0; i_ch_mask = '0; i_ready = 1'b1; i_clear = 1'b0;
        i_adc_eoc = 1'b0; i_adc_dout = '0;
        cycles(3);
        rst_n = 1'b1;
        cycles(1);

        check("rst_chsel", 32'(o_adc_chsel), 32'd1);
        check("rst_soc", 32'(o_adc_soc), 32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_sample", 32'(o_sample), 32'd0);
        check("rst_sample_ch", 32'(o_sample_ch), 32'd0);
        check("rst_overrun", 32'(o_overrun), 32'd0);
        check("rst_timeout", 32'(o_timeout), 32'd0);

        // Enable with an empty mask stays idle.
        i_enable = 1'b1;
        cycles(12);
        check("mask0_soc", 32'(o_adc_soc), 32'd0);
        check("mask0_soc_count", 32'(soc_log.size()), 32'd0);

        // Channels 1 and 3, dout = chsel*0x100.
        adc_mode = 0; eoc_delay = 20; i_ch_mask = 8'b0000_0101;
        cnt = 0;
        while (rcv_val.size() < 4 && cnt < 600) begin cnt++; cycles(1); end
        check("scan_wait", 32'(rcv_val.size() >= 4), 32'd1);
        i_enable = 1'b0;
        cycles(60);
        for (int k = 0; k < 4 && k < rcv_val.size(); k++) begin
            ch = (k % 2 == 0) ? 0 : 2;
            check($sformatf("scan_ch%0d", k), 32'(rcv_ch[k]), 32'(ch));
            check($sformatf("scan_val%0d", k), 32'(rcv_val[k]), 32'(exp_sample(12'((ch + 1) * 256))));
            check($sformatf("scan_chsel%0d", k), 32'(soc_log[k]), 32'(ch + 1));
        end

        // Boundary codes on channel 1, with eoc-to-valid latency.
        codes[0] = 12'h000; codes[1] = 12'h800; codes[2] = 12'hFFF;
        i_ch_mask = 8'b0000_0001; adc_mode = 1; i_ready = 1'b1;
        for (int v = 0; v < 3; v++) begin
            fixed_dout = codes[v];
            clear_logs();
            i_enable = 1'b1;
            ok = 1'b0;
            for (int t = 0; t < 100 && !ok; t++) begin
                @(posedge clk); #1;
                ok = i_adc_eoc;
            end
            check($sformatf("code%0d_eoc_wait", v), 32'(ok), 32'd1);
            check($sformatf("code%0d_valid_lat1", v), 32'(o_valid), 32'd0);
            i_enable = 1'b0;
            @(posedge clk); #1;
            check($sformatf("code%0d_valid_lat2", v), 32'(o_valid), 32'd1);
            check($sformatf("code%0d_sample", v), 32'(o_sample), 32'(exp_sample(codes[v])));
            check($sformatf("code%0d_ch", v), 32'(o_sample_ch), 32'd0);
            cycles(10);
        end

        // Two captures with i_ready low: overrun, second value kept.
        clear_logs();
        adc_mode = 3; i_ready = 1'b0; i_enable = 1'b1;
        cnt = 0;
        while (dout_log.size() < 2 && cnt < 300) begin cnt++; cycles(1); end
        i_enable = 1'b0;
        check("ovr_wait", 32'(dout_log.size()), 32'd2);
        cycles(4);
        held = exp_sample(dout_log[dout_log.size() - 1]);
        check("ovr_flag", 32'(o_overrun), 32'd1);
        check("ovr_valid", 32'(o_valid), 32'd1);
        check("ovr_sample", 32'(o_sample), 32'(held));
        check("ovr_ch", 32'(o_sample_ch), 32'd0);
        cycles(5);
        check("ovr_stable", 32'(o_sample), 32'(held));
        i_clear = 1'b1;
        cycles(1);
        i_clear = 1'b0;
        check("ovr_cleared", 32'(o_overrun), 32'd0);
        check("ovr_valid_kept", 32'(o_valid), 32'd1);
        i_ready = 1'b1;
        cycles(2);
        check("ovr_drained", 32'(o_valid), 32'd0);
        check("ovr_accept_val", 32'(rcv_val.size() == 1 ? rcv_val[0] : 16'hDEAD), 32'(held));

        // eoc never arrives: soc high for the full timeout window, then next channel.
        clear_logs();
        adc_mode = 2; i_ch_mask = 8'b1000_0001; i_enable = 1'b1;
        cnt = 0;
        while (!o_adc_soc && cnt < 50) begin cnt++; cycles(1); end
        check("tmo_chsel_first", 32'(o_adc_chsel), 32'd8);
        cnt = 0;
        while (o_adc_soc && cnt < 1100) begin cnt++; cycles(1); end
        check("tmo_soc_cycles", 32'(cnt), 32'd1023);
        check("tmo_flag", 32'(o_timeout), 32'd1);
        check("tmo_valid", 32'(o_valid), 32'd0);
        check("tmo_no_sample", 32'(rcv_val.size()), 32'd0);
        cnt = 0;
        while (!o_adc_soc && cnt < 50) begin cnt++; cycles(1); end
        check("tmo_chsel_next", 32'(o_adc_chsel), 32'd1);
        i_clear = 1'b1;
        cycles(1);
        i_clear = 1'b0;
        check("tmo_cleared", 32'(o_timeout), 32'd0);

        // Reset in the middle of a conversion.
        cycles(3);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_soc", 32'(o_adc_soc), 32'd0);
        check("rst_mid_valid", 32'(o_valid), 32'd0);
        cycles(2);
        clear_logs();
        i_enable = 1'b0; adc_mode = 0; eoc_delay = 20; i_ch_mask = 8'b0000_0110;
        rst_n = 1'b1;
        cycles(2);

        // Drop enable 5 cycles into CONVERT: one sample, then idle.
        i_enable = 1'b1;
        cnt = 0;
        while (!o_adc_soc && cnt < 50) begin cnt++; cycles(1); end
        check("post_rst_first_chsel", 32'(o_adc_chsel), 32'd2);
        cycles(5);
        i_enable = 1'b0;
        cycles(80);
        check("endrop_samples", 32'(rcv_val.size()), 32'd1);
        check("endrop_val", 32'(rcv_val.size() > 0 ? rcv_val[0] : 16'hDEAD), 32'(exp_sample(12'h200)));
        check("endrop_ch", 32'(rcv_ch.size() > 0 ? rcv_ch[0] : 3'd7), 32'd1);
        check("endrop_soc_count", 32'(soc_log.size()), 32'd1);
        check("endrop_soc_idle", 32'(o_adc_soc), 32'd0);

        // Randomized masks, delays and codes against the round-robin model.
        m_last = 1;
        adc_mode = 3;
        for (int r = 0; r < 3; r++) begin
            clear_logs();
            rmask = 8'($urandom_range(1, 255));
            eoc_delay = int'($urandom_range(3, 25));
            i_ch_mask = rmask;
            i_enable = 1'b1;
            cnt = 0;
            while (rcv_val.size() < 6 && cnt < 800) begin cnt++; cycles(1); end
            i_enable = 1'b0;
            cycles(60);
            n = rcv_val.size();
            check($sformatf("rnd%0d_count", r), 32'(n >= 6), 32'd1);
            check($sformatf("rnd%0d_conv_count", r), 32'(dout_log.size()), 32'(n));
            for (int k = 0; k < n && k < dout_log.size() && k < soc_log.size(); k++) begin
                ch = next_ch(rmask, m_last);
                m_last = ch;
                check($sformatf("rnd%0d_chsel%0d", r, k), 32'(soc_log[k]), 32'(ch + 1));
                check($sformatf("rnd%0d_ch%0d", r, k), 32'(rcv_ch[k]), 32'(ch));
                check($sformatf("rnd%0d_val%0d", r, k), 32'(rcv_val[k]), 32'(exp_sample(dout_log[k])));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
